// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state encoding and byte-enable patterns for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // Big-endian lanes: byte offset 0 lives in BE[3] / data bits [31:24].
  localparam logic [3:0] BE_BYTE0 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b1100;
  localparam logic [3:0] BE_HALF2 = 4'b0011;
  localparam logic [3:0] BE_WORD  = 4'b1111;

endpackage

// File: rtl/lsu_if.sv
// Request/response and DataMemory signals of the load/store unit, bundled as one interface.
interface lsu_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          err;
  logic [AW-1:0] mem_A;
  logic          mem_WE;
  logic [3:0]    mem_BE;
  logic [31:0]   mem_WD;
  logic [31:0]   mem_RD;

  // master: execute stage plus DataMemory; slave: the load/store unit itself.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
    input  req_ready, resp_valid, resp_rdata, err, mem_A, mem_WE, mem_BE, mem_WD
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
    output req_ready, resp_valid, resp_rdata, err, mem_A, mem_WE, mem_BE, mem_WD
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated data / error, and load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wd,
  output logic        err,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic        rd_unsigned,
  input  logic [31:0] rd,
  output logic [31:0] rdata
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be  = '0;
    wd  = '0;
    err = 1'b0;
    case (size_e'(wr_size))
      SZ_BYTE: begin
        be = BE_BYTE0 >> wr_off;
        wd = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        err = wr_off[0];
        be  = wr_off[0] ? 4'b0000 : (wr_off[1] ? BE_HALF2 : BE_HALF0);
        wd  = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        err = (wr_off != 2'b00);
        be  = (wr_off != 2'b00) ? 4'b0000 : BE_WORD;
        wd  = wdata;
      end
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    case (rd_off)
      2'd0:    rd_byte = rd[31:24];
      2'd1:    rd_byte = rd[23:16];
      2'd2:    rd_byte = rd[15:8];
      default: rd_byte = rd[7:0];
    endcase
    rd_half = rd_off[1] ? rd[15:0] : rd[31:16];
    rdata   = '0;
    case (size_e'(rd_size))
      SZ_BYTE: rdata = rd_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: rdata = rd_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      SZ_WORD: rdata = rd;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives DataMemory and returns extended load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int AW         = 32
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  localparam int CW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MEM_RD_LAT > 0) ? MEM_RD_LAT - 1 : 0);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] mem_a_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wd_q;
  logic          mem_we_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic          uns_q;
  logic          we_q;
  logic [31:0]   rdata_q;

  logic [3:0]    a_be;
  logic [31:0]   a_wd;
  logic          a_err;
  logic [31:0]   x_rdata;

  lsu_align u_align (
    .wr_size     (bus.req_size),
    .wr_off      (bus.req_addr[1:0]),
    .wdata       (bus.req_wdata),
    .be          (a_be),
    .wd          (a_wd),
    .err         (a_err),
    .rd_size     (size_q),
    .rd_off      (off_q),
    .rd_unsigned (uns_q),
    .rd          (bus.mem_RD),
    .rdata       (x_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      mem_a_q  <= '0;
      mem_be_q <= '0;
      mem_wd_q <= '0;
      mem_we_q <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            size_q  <= bus.req_size;
            off_q   <= bus.req_addr[1:0];
            uns_q   <= bus.req_unsigned;
            we_q    <= bus.req_we;
            rdata_q <= '0;
            if (a_err) begin
              state <= ST_ERR;
            end else begin
              state    <= ST_ACCESS;
              mem_a_q  <= {bus.req_addr[AW-1:2], 2'b00};
              mem_be_q <= a_be;
              mem_wd_q <= a_wd;
              mem_we_q <= bus.req_we;
            end
          end
        end
        ST_ACCESS: begin
          if (we_q || MEM_RD_LAT == 0) begin
            state    <= ST_RESP;
            rdata_q  <= we_q ? '0 : x_rdata;
            mem_a_q  <= '0;
            mem_be_q <= '0;
            mem_wd_q <= '0;
          end else begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_LAST) begin
            state    <= ST_RESP;
            rdata_q  <= x_rdata;
            mem_a_q  <= '0;
            mem_be_q <= '0;
            mem_wd_q <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          rdata_q <= '0;
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP) || (state == ST_ERR);
  assign bus.err        = (state == ST_ERR);
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_A      = mem_a_q;
  assign bus.mem_BE     = mem_be_q;
  assign bus.mem_WD     = mem_wd_q;
  assign bus.mem_WE     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array reference model plus a registered DataMemory stub.
module tb_load_store_unit;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  always #5 clk = ~clk;

  lsu_if #(.AW(32)) bus ();

  load_store_unit #(.MEM_RD_LAT(LAT), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // DataMemory stub: 16 words, one-cycle registered read, byte-enabled writes.
  logic [31:0] dmem [16] = '{default: 32'h0};
  logic [31:0] mem_rd_q = 32'h0;

  always @(posedge clk) begin
    mem_rd_q <= dmem[bus.mem_A[5:2]];
    if (bus.mem_WE)
      for (int o = 0; o < 4; o++)
        if (bus.mem_BE[3-o]) dmem[bus.mem_A[5:2]][31-8*o -: 8] = bus.mem_WD[31-8*o -: 8];
  end

  assign bus.mem_RD = mem_rd_q;

  // Reference model: byte-addressed memory, big-endian (lowest address = most significant byte).
  logic [7:0] ref_bytes [64] = '{default: 8'h0};

  function automatic int size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input int a, input int n, input logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_bytes[a+k]);
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input int a, input int n, input logic [31:0] data);
    logic [31:0] t;
    for (int k = 0; k < n; k++) begin
      t = data >> (8*(n-1-k));
      ref_bytes[a+k] = t[7:0];
    end
  endtask

  // One complete transaction with every observable compared against the model.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                         output logic [31:0] got_rdata, output logic [3:0] got_be,
                         output logic [31:0] got_wd);
    int          n, a, k, we_cnt, xlat;
    logic        e, seen, bad;
    logic [3:0]  xbe;
    logic [31:0] xwd, xrd, t, a1;
    n = size_bytes(size);
    a = int'(addr[5:0]);
    e = (n == 0) || ((a % n) != 0);
    xbe = 4'b0;
    xwd = 32'h0;
    if (!e) begin
      for (int k2 = 0; k2 < n; k2++) xbe[3-(a%4)-k2] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        t = wdata >> (8*(n-1-(j % n)));
        xwd[31-8*j -: 8] = t[7:0];
      end
    end
    xrd  = (e || we) ? 32'h0 : model_load(a, n, uns);
    xlat = e ? 1 : (we ? 2 : LAT + 2);
    got_rdata = 32'h0; got_be = 4'b0; got_wd = 32'h0; a1 = 32'h0;

    @(negedge clk);
    bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    chk_cnt++;
    if (!bus.req_ready) begin
      $display("FAIL %s accept timeout: req_ready got 0 want 1", tag);
      bus.req_valid = 1'b0;
      return;
    end
    pass_cnt++;
    @(posedge clk);
    k = 0; seen = 1'b0; we_cnt = 0; bad = 1'b0;
    while (!seen && k < LAT + 10) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom; bus.req_addr = $urandom; bus.req_size = 2'($urandom);
        got_be = bus.mem_BE; got_wd = bus.mem_WD; a1 = bus.mem_A;
      end
      if (bus.mem_WE) we_cnt++;
      if (e && (bus.mem_BE != 4'b0 || bus.mem_WE)) bad = 1'b1;
      if (bus.resp_valid) seen = 1'b1;
    end
    got_rdata = bus.resp_rdata;

    chk_cnt++;
    if (!seen || k != xlat) $display("FAIL %s latency got %0d (seen=%0b) want %0d", tag, k, seen, xlat);
    else pass_cnt++;
    chk_cnt++;
    if (bus.err !== e) $display("FAIL %s err got %0b want %0b", tag, bus.err, e);
    else pass_cnt++;
    chk_cnt++;
    if (got_rdata !== xrd) $display("FAIL %s rdata got %08h want %08h", tag, got_rdata, xrd);
    else pass_cnt++;
    chk_cnt++;
    if (we_cnt != ((we && !e) ? 1 : 0)) $display("FAIL %s mem_WE cycles got %0d want %0d", tag, we_cnt, (we && !e) ? 1 : 0);
    else pass_cnt++;
    chk_cnt++;
    if (bus.mem_BE !== 4'b0 || bus.mem_WE !== 1'b0 || bus.mem_A !== 32'h0)
      $display("FAIL %s mem idle at resp got BE=%04b WE=%0b A=%08h want 0", tag, bus.mem_BE, bus.mem_WE, bus.mem_A);
    else pass_cnt++;
    if (e) begin
      chk_cnt++;
      if (bad) $display("FAIL %s memory touched on error got BE/WE active want 0", tag);
      else pass_cnt++;
    end else begin
      chk_cnt++;
      if (got_be !== xbe || a1 !== (addr & ~32'h3))
        $display("FAIL %s mem_BE/mem_A got %04b/%08h want %04b/%08h", tag, got_be, a1, xbe, addr & ~32'h3);
      else pass_cnt++;
      if (we) begin
        chk_cnt++;
        if (got_wd !== xwd) $display("FAIL %s mem_WD got %08h want %08h", tag, got_wd, xwd);
        else pass_cnt++;
        model_store(a, n, wdata);
      end
    end
  endtask

  task automatic test_reset();
    chk_cnt++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.err !== 1'b0 || bus.resp_rdata !== 32'h0 ||
        bus.mem_WE !== 1'b0 || bus.mem_BE !== 4'b0 || bus.mem_A !== 32'h0 || bus.mem_WD !== 32'h0)
      $display("FAIL reset outputs got rdy=%0b rv=%0b err=%0b rd=%08h WE=%0b BE=%04b A=%08h WD=%08h want 1,0,0,0,0,0,0,0",
               bus.req_ready, bus.resp_valid, bus.err, bus.resp_rdata, bus.mem_WE, bus.mem_BE, bus.mem_A, bus.mem_WD);
    else pass_cnt++;
  endtask

  task automatic test_store_byte_lanes();
    logic [3:0]  lane_be [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [31:0] rd, wd;
    logic [3:0]  be;
    for (int o = 0; o < 4; o++) begin
      run_txn(1'b1, 2'b00, 1'b0, 32'(o), 32'h0000_00FF, $sformatf("sb_off%0d", o), rd, be, wd);
      chk_cnt++;
      if (be !== lane_be[o] || wd !== 32'hFFFF_FFFF)
        $display("FAIL sb_lane%0d got BE=%04b WD=%08h want %04b FFFFFFFF", o, be, wd, lane_be[o]);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_byte();
    logic [31:0] rd, wd;
    logic [3:0]  be;
    run_txn(1'b1, 2'b10, 1'b0, 32'h0, 32'h12F4_5678, "sw_preload", rd, be, wd);
    run_txn(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, "lb_signed", rd, be, wd);
    chk_cnt++;
    if (rd !== 32'hFFFF_FFF4) $display("FAIL lb_signed_value got %08h want FFFFFFF4", rd);
    else pass_cnt++;
    run_txn(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, "lbu", rd, be, wd);
    chk_cnt++;
    if (rd !== 32'h0000_00F4) $display("FAIL lbu_value got %08h want 000000F4", rd);
    else pass_cnt++;
  endtask

  task automatic test_half_word();
    logic [31:0] rd, wd;
    logic [3:0]  be;
    run_txn(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_ABCD, "sh_off2", rd, be, wd);
    chk_cnt++;
    if (be !== 4'b0011 || wd !== 32'hABCD_ABCD) $display("FAIL sh_lanes got BE=%04b WD=%08h want 0011 ABCDABCD", be, wd);
    else pass_cnt++;
    run_txn(1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_8001, "sw_8001", rd, be, wd);
    run_txn(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, "lh_signed", rd, be, wd);
    chk_cnt++;
    if (rd !== 32'hFFFF_8001) $display("FAIL lh_value got %08h want FFFF8001", rd);
    else pass_cnt++;
    run_txn(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, "lw", rd, be, wd);
    chk_cnt++;
    if (rd !== 32'h0000_8001) $display("FAIL lw_value got %08h want 00008001", rd);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] rd, wd;
    logic [3:0]  be;
    run_txn(1'b1, 2'b10, 1'b0, 32'h6, 32'hDEAD_BEEF, "err_sw_misaligned", rd, be, wd);
    run_txn(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, "err_lh_misaligned", rd, be, wd);
    run_txn(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, "err_size11", rd, be, wd);
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd, wd;
    logic [3:0]  be;
    logic        rv_seen;
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h1; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (bus.mem_BE !== 4'b0100 || bus.mem_WE !== 1'b0 || bus.resp_valid !== 1'b0)
      $display("FAIL wait_state got BE=%04b WE=%0b rv=%0b want 0100 0 0", bus.mem_BE, bus.mem_WE, bus.resp_valid);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    chk_cnt++;
    if (bus.mem_BE !== 4'b0 || bus.mem_A !== 32'h0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL rst_in_wait got BE=%04b A=%08h rv=%0b rdy=%0b want 0 0 0 1", bus.mem_BE, bus.mem_A, bus.resp_valid, bus.req_ready);
    else pass_cnt++;
    rv_seen = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.resp_valid) rv_seen = 1'b1; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.resp_valid) rv_seen = 1'b1; end
    chk_cnt++;
    if (rv_seen || bus.req_ready !== 1'b1) $display("FAIL rst_abort got rv_seen=%0b rdy=%0b want 0 1", rv_seen, bus.req_ready);
    else pass_cnt++;
    run_txn(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, "lh_after_rst", rd, be, wd);
    chk_cnt++;
    if (rd !== 32'hFFFF_8001) $display("FAIL lh_after_rst_value got %08h want FFFF8001", rd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  we_h, rv_h, rdy_h;
    logic [3:0]  be4;
    logic [31:0] wd4, rd, wd;
    logic [3:0]  be;
    int          k;
    @(negedge clk);
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h8; bus.req_wdata = 32'h0000_005A; bus.req_valid = 1'b1;
    @(posedge clk);
    we_h = '0; rv_h = '0; rdy_h = '0; be4 = '0; wd4 = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_size = 2'b01; bus.req_addr = 32'hE; bus.req_wdata = 32'h0000_1234;
      end
      we_h[c-1] = bus.mem_WE; rv_h[c-1] = bus.resp_valid; rdy_h[c-1] = bus.req_ready;
      if (c == 4) begin be4 = bus.mem_BE; wd4 = bus.mem_WD; bus.req_valid = 1'b0; end
    end
    chk_cnt++;
    if (we_h !== 6'b001001) $display("FAIL b2b_we_pulses got %06b want 001001", we_h);
    else pass_cnt++;
    chk_cnt++;
    if (rv_h !== 6'b010010 || rdy_h !== 6'b100100)
      $display("FAIL b2b_resp_ready got rv=%06b rdy=%06b want 010010 100100", rv_h, rdy_h);
    else pass_cnt++;
    chk_cnt++;
    if (be4 !== 4'b0011 || wd4 !== 32'h1234_1234) $display("FAIL b2b_second got BE=%04b WD=%08h want 0011 12341234", be4, wd4);
    else pass_cnt++;
    model_store(8, 1, 32'h5A);
    model_store(14, 2, 32'h1234);
    run_txn(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, "b2b_readback0", rd, be, wd);
    run_txn(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, "b2b_readback1", rd, be, wd);
  endtask

  task automatic test_random();
    logic [31:0] rd, wd;
    logic [3:0]  be;
    for (int i = 0; i < 60; i++)
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 63)), $urandom, $sformatf("rand%0d", i), rd, be, wd);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_store_byte_lanes();
    test_load_byte();
    test_half_word();
    test_errors();
    test_reset_in_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the execute stage and DataMemory and owns every data-memory access.
- Accepts one load/store request at a time.
- Generates the word address, byte enables (BE) and lane-replicated write data.
- Waits out the memory read latency, then extracts and sign/zero-extends the addressed byte, half or word.
- Flags misaligned or illegal-size accesses without touching memory.

Parameters:
- MEM_RD_LAT, 1: cycles from address presented on mem_A to valid mem_RD (0 = combinational read).
- AW, 32: address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: zero-extend if 1, sign-extend if 0.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data (0 for stores and errors).
- err  out  1  valid with resp_valid; misaligned or illegal size.
- mem_A  out  AW  word-aligned address {req_addr[AW-1:2],2'b00}.
- mem_WE  out  1  DataMemory write enable.
- mem_BE  out  4  byte enables, big-endian lanes.
- mem_WD  out  32  lane-replicated write data.
- mem_RD  in  32  DataMemory read data.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - mem_WE, mem_BE, mem_A, mem_WD, resp_valid, resp_rdata and err all read 0.
  - req_ready reads 1, as a decode of IDLE.
  - An in-flight access is aborted: no resp_valid, and mem_WE drops in the same instant.
- Handshake:
  - A request is accepted on a rising edge when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - resp_valid has no back-pressure.
- Lane mapping (big-endian): byte offset o = req_addr[1:0] maps to lane BE[3-o] / data bits [31-8o -: 8].
- Byte enables and write data:
  - Byte: BE = 4'b1000>>o; WD = {4{wdata[7:0]}}.
  - Half: o=0 gives BE 1100; o=2 gives BE 0011; WD = {2{wdata[15:0]}}.
  - Word: o=0 only, BE 1111, WD = wdata.
- Error condition: half with o[0]=1, word with o≠0, or size 11.
- FSM states: IDLE, ACCESS, WAIT, RESP, ERR.
  - IDLE → ERR on accepting an erroneous request. Memory outputs stay 0.
  - IDLE → ACCESS on accepting a legal request. mem_A/BE/WD are registered, and mem_WE = req_we is registered for exactly one cycle.
  - ACCESS → RESP for a store.
  - ACCESS → WAIT for a load with MEM_RD_LAT ≥ 1.
  - ACCESS → RESP for a load with MEM_RD_LAT = 0; mem_RD is sampled on the ACCESS exit edge.
  - WAIT holds mem_A/BE with mem_WE=0. It counts MEM_RD_LAT cycles using a $clog2 counter. mem_RD is sampled into the extract register on the final WAIT edge; then → RESP.
  - RESP: resp_valid=1, err=0, resp_rdata = extracted data (0 for a store); then → IDLE.
  - ERR: resp_valid=1, err=1, resp_rdata=0; then → IDLE.
- Memory outputs return to 0 on entry to RESP or IDLE.
- Load latency: resp_valid is seen MEM_RD_LAT+2 cycles after the accept edge.
- Store latency: resp_valid is seen 2 cycles after the accept edge.
- Error latency: resp_valid is seen 1 cycle after the accept edge.
- Extraction:
  - Byte = mem_RD[31-8o -: 8].
  - Half = mem_RD[31:16] for o=0, mem_RD[15:0] for o=2.
  - Extended to 32 bits per req_unsigned; words pass unchanged.
- Offset, size and unsigned are registered at accept, so req_* may change after acceptance.
- Back-to-back requests: a held req_valid is next accepted in the cycle after RESP/ERR (in IDLE). No request is ever accepted in RESP.

Decomposition:
- lsu_pkg holds:
  - Size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL.
  - The FSM state enum.
  - BE constants BE_BYTE0 = 4'b1000, BE_HALF0 = 4'b1100, BE_HALF2 = 4'b0011, BE_WORD = 4'b1111.
- One combinational sub-module, lsu_align, covers:
  - (size, offset, wdata) → (BE, WD, err).
  - (size, offset, unsigned, RD) → rdata.
- load_store_unit holds the FSM, registers and wait counter.

Test Plan:
1. Store byte at addr 0x0, wdata 0xFF → mem_BE=1000, mem_WD=0xFFFFFFFF, mem_A=0, mem_WE high exactly 1 cycle after accept; resp_valid 2 cycles after accept, err=0. Repeat for addr 1/2/3 → BE 0100/0010/0001.
2. Load byte signed at addr 0x1, mem_RD=0x12F45678, LAT=1 → resp_rdata=0xFFFFFFF4 at cycle 3; same with req_unsigned=1 → 0x000000F4.
3. Store half at addr 0x2, wdata 0xABCD → BE=0011, WD=0xABCDABCD. Then load half signed at addr 0x2 with mem_RD=0x00008001 → 0xFFFF8001; word load at addr 0x0 → 0x00008001.
4. Word store at addr 0x6 → resp_valid+err next cycle, mem_WE/mem_BE stay 0. Half load at addr 0x1 and size=11 → same.
5. Assert rst in WAIT → mem_BE/mem_A immediately 0 and no resp_valid. After release, req_ready=1 and a fresh load completes with correct data.
6. req_valid held for two stores → second accept exactly one cycle after the first resp_valid; mem_WE pulses never overlap or merge.
